// File: rtl/timestamp_pkg.sv
// Shared constants and types for the timestamp serializer slice.
// Holds ASCII codes, frame lengths, FSM state encoding and the snapshot record.
// Pure declarations; no logic lives here.
package timestamp_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Plain frame: "MM-DD hh:mm:ss\r\n"; checksum frame adds "*HH" before CR
    localparam int FRAME_LEN_PLAIN = 16;
    localparam int FRAME_LEN_CSUM  = 19;
    // Number of leading bytes folded into the checksum
    localparam int CSUM_SPAN       = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAP_A = 2'd1,
        CAP_B = 2'd2,
        SEND  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] mon;
        logic [4:0] day;
        logic [4:0] hour;
        logic [5:0] minute;
        logic [5:0] sec;
    } stamp_t;

    // Uppercase hex digit for one nibble
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (ASCII_0 + {4'b0000, nib}) : (8'h37 + {4'b0000, nib});
    endfunction

endpackage

// File: rtl/timestamp_serializer_bin2ascii2.sv
// Converts a 6-bit binary value (0..63) into two ASCII decimal digits, tens first.
// Purely combinational, zero latency.
// No handshake; output follows input.
module bin2ascii2
    import timestamp_pkg::*;
(
    input  logic [5:0] bin,
    output logic [7:0] tens_ascii,
    output logic [7:0] ones_ascii
);

    logic [2:0] tens;
    logic [3:0] ones;

    // Compare-subtract from the largest decade down; first hit fixes the tens digit
    always_comb begin
        tens = 3'd0;
        ones = bin[3:0];
        for (int k = 6; k >= 1; k--) begin
            if ((tens == 3'd0) && (bin >= 6'(k * 10))) begin
                tens = 3'(k);
                ones = 4'(bin - 6'(k * 10));
            end
        end
    end

    assign tens_ascii = ASCII_0 + {5'b00000, tens};
    assign ones_ascii = ASCII_0 + {4'b0000, ones};

endmodule

// File: rtl/timestamp_serializer.sv
// Captures a tear-free date/time snapshot on min15 or send_req and streams it as an ASCII frame.
// Latency: first byte valid 3 clk after trigger (+2 per re-capture); min15 edge seen SYNC_STAGES+1 clk late.
// Backpressure: valid/ready on tx; data held while stalled; one trigger queued, further ones set overrun.
// Optional checksum suffix "*HH" enabled by defining TIMESTAMP_SERIALIZER_CHECKSUM_EN.
module timestamp_serializer
    import timestamp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       min15,
    input  logic       send_req,
    input  logic [5:0] sec_i,
    input  logic [5:0] min_i,
    input  logic [4:0] hour_i,
    input  logic [4:0] day_i,
    input  logic [3:0] mon_i,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       overrun
);

`ifdef TIMESTAMP_SERIALIZER_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
    localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif
    localparam int                 RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [4:0]         LAST_IDX  = 5'(FRAME_LEN - 1);

    state_t               state;
    state_t               state_n;
    logic [SYNC_STAGES-1:0] min15_sync;
    logic                 min15_last;
    logic                 min15_rise;
    logic                 trig;
    stamp_t               live;
    stamp_t               snap_a;
    stamp_t               snap_b;
    logic                 mismatch;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [4:0]           byte_idx;
    logic                 last_xfer;
    logic                 pending;
    logic [7:0]           frame_byte;

    logic [7:0] mon_hi, mon_lo, day_hi, day_lo, hour_hi, hour_lo;
    logic [7:0] min_hi, min_lo, sec_hi, sec_lo;

    assign live = '{mon: mon_i, day: day_i, hour: hour_i, minute: min_i, sec: sec_i};

    // Synchronize min15 into clk and keep one extra flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            min15_sync <= '0;
            min15_last <= 1'b0;
        end else begin
            min15_sync <= {min15_sync[SYNC_STAGES-2:0], min15};
            min15_last <= min15_sync[SYNC_STAGES-1];
        end
    end

    // A simultaneous min15 edge and send_req collapse into a single trigger
    assign min15_rise = min15_sync[SYNC_STAGES-1] & ~min15_last;
    assign trig       = min15_rise | send_req;
    assign mismatch   = (snap_a != live);
    assign last_xfer  = (state == SEND) && tx_ready && (byte_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: double capture with bounded re-capture, then stream the frame
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (trig) state_n = CAP_A;
            CAP_A:   state_n = CAP_B;
            CAP_B:   state_n = (mismatch && (retry_cnt < RETRY_MAX)) ? CAP_A : SEND;
            SEND:    if (last_xfer) state_n = (pending || trig) ? CAP_A : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Snapshot, retry counter and byte index; snap_b stays frozen outside CAP_B
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_a    <= '0;
            snap_b    <= '0;
            retry_cnt <= '0;
            byte_idx  <= '0;
        end else begin
            if (state == CAP_A) begin
                snap_a <= live;
            end
            if (state == CAP_B) begin
                snap_b    <= live;
                retry_cnt <= (mismatch && (retry_cnt < RETRY_MAX)) ? retry_cnt + RETRY_W'(1) : '0;
            end
            if ((state == SEND) && tx_ready) begin
                byte_idx <= (byte_idx == LAST_IDX) ? 5'd0 : byte_idx + 5'd1;
            end
        end
    end

    // One trigger may wait while busy; a second one while waiting is lost and flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if ((state != IDLE) && trig && pending) begin
                overrun <= 1'b1;
            end
            if (last_xfer) begin
                pending <= 1'b0;
            end else if ((state != IDLE) && trig) begin
                pending <= 1'b1;
            end
        end
    end

    bin2ascii2 u_mon  (.bin({2'b00, snap_b.mon}),  .tens_ascii(mon_hi),  .ones_ascii(mon_lo));
    bin2ascii2 u_day  (.bin({1'b0, snap_b.day}),   .tens_ascii(day_hi),  .ones_ascii(day_lo));
    bin2ascii2 u_hour (.bin({1'b0, snap_b.hour}),  .tens_ascii(hour_hi), .ones_ascii(hour_lo));
    bin2ascii2 u_min  (.bin(snap_b.minute),        .tens_ascii(min_hi),  .ones_ascii(min_lo));
    bin2ascii2 u_sec  (.bin(snap_b.sec),           .tens_ascii(sec_hi),  .ones_ascii(sec_lo));

`ifdef TIMESTAMP_SERIALIZER_CHECKSUM_EN
    logic [7:0] csum;

    // Fold each of the leading frame bytes into the checksum as it is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= 8'h00;
        end else if (state == CAP_B) begin
            csum <= 8'h00;
        end else if ((state == SEND) && tx_ready && (byte_idx < 5'(CSUM_SPAN))) begin
            csum <= csum ^ tx_data;
        end
    end
`endif

    // Byte index to frame character
    always_comb begin
        frame_byte = 8'h00;
        case (byte_idx)
            5'd0:  frame_byte = mon_hi;
            5'd1:  frame_byte = mon_lo;
            5'd2:  frame_byte = ASCII_DASH;
            5'd3:  frame_byte = day_hi;
            5'd4:  frame_byte = day_lo;
            5'd5:  frame_byte = ASCII_SPACE;
            5'd6:  frame_byte = hour_hi;
            5'd7:  frame_byte = hour_lo;
            5'd8:  frame_byte = ASCII_COLON;
            5'd9:  frame_byte = min_hi;
            5'd10: frame_byte = min_lo;
            5'd11: frame_byte = ASCII_COLON;
            5'd12: frame_byte = sec_hi;
            5'd13: frame_byte = sec_lo;
`ifdef TIMESTAMP_SERIALIZER_CHECKSUM_EN
            5'd14: frame_byte = ASCII_STAR;
            5'd15: frame_byte = hex_ascii(csum[7:4]);
            5'd16: frame_byte = hex_ascii(csum[3:0]);
            5'd17: frame_byte = ASCII_CR;
            5'd18: frame_byte = ASCII_LF;
`else
            5'd14: frame_byte = ASCII_CR;
            5'd15: frame_byte = ASCII_LF;
`endif
            default: frame_byte = 8'h00;
        endcase
    end

    // Outputs decoded from state; tx_data is zero whenever nothing is offered
    always_comb begin
        tx_valid = (state == SEND);
        tx_data  = (state == SEND) ? frame_byte : 8'h00;
        busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_timestamp_serializer.sv
// Scoreboarded bench: stimulus pushes expected frame bytes, a monitor pops and compares on each offered byte.
// Reference frames are built from the field values with decimal/hex arithmetic.
// Covers reset, latency, stalls, random fields, re-capture, pending/overrun and mid-frame reset.
module tb_timestamp_serializer;

`ifdef TIMESTAMP_SERIALIZER_CHECKSUM_EN
    localparam int FLEN = 19;
`else
    localparam int FLEN = 16;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       min15;
    logic       send_req;
    logic [5:0] sec_i;
    logic [5:0] min_i;
    logic [4:0] hour_i;
    logic [4:0] day_i;
    logic [3:0] mon_i;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int n_xfer = 0;
    int ready_mode = 0;
    byte unsigned exp_q[$];

    timestamp_serializer dut (
        .clk(clk), .rst(rst), .min15(min15), .send_req(send_req),
        .sec_i(sec_i), .min_i(min_i), .hour_i(hour_i), .day_i(day_i), .mon_i(mon_i),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .overrun(overrun)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic byte unsigned hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    // Expected frame from the field values
    function automatic void push_frame(input int mo, dy, hr, mn, sc);
        byte unsigned f[$];
        int vals[5];
        int x;
        vals = '{mo, dy, hr, mn, sc};
        f = {};
        for (int i = 0; i < 5; i++) begin
            f.push_back(8'(48 + vals[i] / 10));
            f.push_back(8'(48 + vals[i] % 10));
            if (i == 0) f.push_back(8'h2D);
            if (i == 1) f.push_back(8'h20);
            if (i == 2 || i == 3) f.push_back(8'h3A);
        end
`ifdef TIMESTAMP_SERIALIZER_CHECKSUM_EN
        x = 0;
        for (int i = 0; i < 14; i++) x = x ^ int'(f[i]);
        f.push_back(8'h2A);
        f.push_back(hexc(x / 16));
        f.push_back(hexc(x % 16));
`else
        x = 0;
`endif
        f.push_back(8'h0D);
        f.push_back(8'h0A);
        foreach (f[i]) exp_q.push_back(f[i]);
    endfunction

    task automatic set_fields(input int mo, dy, hr, mn, sc);
        mon_i = 4'(mo); day_i = 5'(dy); hour_i = 5'(hr); min_i = 6'(mn); sec_i = 6'(sc);
    endtask

    task automatic pulse_req();
        @(posedge clk); #1; send_req = 1'b1;
        @(posedge clk); #1; send_req = 1'b0;
    endtask

    // Monitor: every offered byte must match the queue head; pop on transfer
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && tx_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_byte: got %02h expected none", tx_data);
                end else begin
                    if (tx_data !== exp_q[0]) begin
                        n_bad++;
                        $display("FAIL byte_%0d: got %02h expected %02h", n_xfer, tx_data, exp_q[0]);
                    end
                    if (tx_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                        n_xfer++;
                    end
                end
            end
        end
    end

    // tx_ready pattern: 0 always, 1 one-of-three, 2 random, 3 held low
    initial begin
        int k;
        k = 0;
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            k++;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (k % 3 == 0);
                2:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_frame(input int mo, dy, hr, mn, sc, input int rmode, input string tag);
        int lat;
        int burst;
        int base;
        set_fields(mo, dy, hr, mn, sc);
        ready_mode = rmode;
        push_frame(mo, dy, hr, mn, sc);
        base = n_xfer;
        pulse_req();
        lat = 1;
        while (!tx_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check({tag, "_latency"}, lat, 3);
        burst = 0;
        while (busy && burst < 400) begin @(posedge clk); #1; burst++; end
        check({tag, "_idle"}, busy, 0);
        if (rmode == 0) check({tag, "_burst_len"}, burst, FLEN);
        check({tag, "_xfers"}, n_xfer - base, FLEN);
    endtask

    initial begin
        int lat;
        int base;
        int cnt;
        rst = 1'b1; min15 = 1'b0; send_req = 1'b0;
        set_fields(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        do_frame(3, 7, 9, 5, 42, 0, "basic");
        do_frame(3, 7, 9, 5, 42, 1, "stall");
        for (int i = 0; i < 8; i++) begin
            do_frame($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 2), "rand");
        end
        do_frame(12, 29, 23, 59, 59, 0, "fields_max");

        // Seconds roll between the two captures: one re-capture, post-roll values sent
        set_fields(2, 3, 10, 14, 59);
        ready_mode = 0;
        push_frame(2, 3, 10, 15, 0);
        base = n_xfer;
        pulse_req();
        @(posedge clk); #1;
        set_fields(2, 3, 10, 15, 0);
        lat = 2;
        while (!tx_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("retry_latency", lat, 5);
        cnt = 0;
        while (busy && cnt < 400) begin @(posedge clk); #1; cnt++; end
        check("retry_xfers", n_xfer - base, FLEN);
        check("pre_overrun", overrun, 0);

        // Triggers during a stalled frame: one queued, two dropped
        set_fields(1, 2, 3, 4, 5);
        ready_mode = 3;
        push_frame(1, 2, 3, 4, 5);
        push_frame(1, 2, 3, 4, 5);
        base = n_xfer;
        pulse_req();
        cnt = 0;
        while (!tx_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
        check("pend_started", tx_valid, 1);
        #3 min15 = 1'b1;
        repeat (6) @(posedge clk);
        #3 min15 = 1'b0;
        repeat (2) @(posedge clk);
        check("pend_no_overrun_yet", overrun, 0);
        pulse_req();
        repeat (2) @(posedge clk);
        pulse_req();
        #1;
        check("pend_overrun_mid", overrun, 1);
        ready_mode = 0;
        cnt = 0;
        while (busy && cnt < 400) begin @(posedge clk); #1; cnt++; end
        check("pend_two_frames", n_xfer - base, 2 * FLEN);
        check("pend_queue_empty", exp_q.size(), 0);
        check("pend_overrun_sticky", overrun, 1);
        repeat (30) @(posedge clk);
        #1;
        check("pend_no_third_frame", busy, 0);

        // Reset while byte 8 is offered: frame abandoned
        set_fields(11, 22, 13, 44, 55);
        ready_mode = 0;
        push_frame(11, 22, 13, 44, 55);
        base = n_xfer;
        pulse_req();
        cnt = 0;
        while ((n_xfer - base) < 8 && cnt < 100) begin @(posedge clk); #1; cnt++; end
        check("rstmid_at_byte8", n_xfer - base, 8);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_tx_valid", tx_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_tx_data", tx_data, 0);
        check("rstmid_overrun", overrun, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (tx_valid || busy) cnt++;
        end
        check("rstmid_no_resume", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
